// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end that sits directly upstream of decode.
//   It generates sequential fetch PCs and issues in-order requests to the
//   instruction cache. Cache responses are buffered in a DEPTH-entry FIFO,
//   and the FIFO head is presented to decode as INSTRUCTION/INS_PC.
//   A redirect (branch, jump or flush) clears the FIFO, reloads the PC, and
//   arranges for every response still in flight to be dropped.
//
// Ports
//   CLK          in   1   clock; all state changes on the rising edge
//   RST          in   1   synchronous reset, active-high
//   REDIRECT     in   1   restart fetch at REDIRECT_PC
//   REDIRECT_PC  in   32  new fetch address (word aligned)
//   REQ_VALID    out  1   fetch request valid
//   REQ_ADDR     out  32  fetch address (current PC)
//   REQ_READY    in   1   cache accepts the request this cycle
//   RESP_VALID   in   1   cache returns one instruction, in request order
//   RESP_DATA    in   32  returned instruction word
//   DEC_READY    in   1   decode consumes the head this cycle
//   INSTRUCTION  out  32  FIFO head word, NOP when empty
//   INS_PC       out  32  PC of FIFO head, 0 when empty
//   INS_VALID    out  1   FIFO non-empty
//
// Handshakes
//   Request: a request transfers on a cycle where REQ_VALID && REQ_READY.
//     REQ_VALID does not wait for REQ_READY.
//   Response: RESP_VALID has no back-pressure. Credit accounting guarantees
//     a free slot for every response.
//   Decode: the head transfers on a cycle where INS_VALID && DEC_READY and
//     no redirect is active.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        REQ_VALID,
  output logic [31:0] REQ_ADDR,
  input  logic        REQ_READY,
  input  logic        RESP_VALID,
  input  logic [31:0] RESP_DATA,
  input  logic        DEC_READY,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] INS_PC,
  output logic        INS_VALID
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [CW:0]   occupancy;
  logic          resp_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] count_nxt;

  assign REQ_ADDR = pc;

  always_comb begin
    occupancy       = {1'b0, count} + {1'b0, outstanding};
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_ok         = RESP_VALID && (outstanding != '0);
    // Credit rule: buffered plus in-flight entries never exceed DEPTH.
    REQ_VALID       = !RST && !REDIRECT && (occupancy < DEPTH_W);
    issue           = REQ_VALID && REQ_READY;
    INS_VALID       = (count != '0);
    // A redirect voids both the incoming response and any pop this cycle.
    push            = resp_ok && !REDIRECT && (discard == '0);
    pop             = INS_VALID && DEC_READY && !REDIRECT;

    outstanding_nxt = outstanding;
    if (issue && !resp_ok)
      outstanding_nxt = outstanding + C_ONE;
    else if (!issue && resp_ok)
      outstanding_nxt = outstanding - C_ONE;

    count_nxt = count;
    if (push && !pop)
      count_nxt = count + C_ONE;
    else if (!push && pop)
      count_nxt = count - C_ONE;

    INSTRUCTION = NOP;
    INS_PC      = 32'h0000_0000;
    if (INS_VALID) begin
      INSTRUCTION = data_mem[rd_ptr];
      INS_PC      = pc_mem[rd_ptr];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      // Outstanding keeps tracking real cache traffic, even across a redirect.
      outstanding <= outstanding_nxt;
      if (REDIRECT) begin
        pc      <= REDIRECT_PC;
        resp_pc <= REDIRECT_PC;
        count   <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        // No request issues in a redirect cycle. Every request still in
        // flight after this edge belongs to the old stream.
        discard <= outstanding_nxt;
      end else begin
        count <= count_nxt;
        if (issue)
          pc <= pc + 32'd4;
        if (pop)
          rd_ptr <= rd_ptr + P_ONE;
        if (push) begin
          wr_ptr  <= wr_ptr + P_ONE;
          resp_pc <= resp_pc + 32'd4;
        end
        if (resp_ok && (discard != '0))
          discard <= discard - C_ONE;
      end
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      data_mem[wr_ptr] <= RESP_DATA;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

endmodule
